// File: rtl/addsub_result_display_if.sv
// Handshake and display bundle between the add/subtract unit, this display stage
// and the 7-segment pins.
interface addsub_result_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] S;
  logic       sign;
  logic       disp_valid;
  logic [6:0] seg;
  logic [2:0] an;

  // Producer side: drives the result, observes readiness and the display pins.
  modport master (
    output in_valid, S, sign,
    input  in_ready, disp_valid, seg, an
  );

  // Display stage side.
  modport slave (
    input  in_valid, S, sign,
    output in_ready, disp_valid, seg, an
  );
endinterface

// File: rtl/addsub_result_display.sv
// Accepts a 5-bit magnitude plus sign, converts it to BCD with a 5-step double-dabble
// and scans it onto a 3-digit common-anode 7-segment display (sign, tens, ones).
module addsub_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  addsub_result_display_if.slave  bus
);

  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    LAST_IT  = 3'd4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [12:0] scratch_q, scratch_d;
  logic [2:0]  iter_q, iter_d;
  logic        sign_q, sign_d;
  logic        commit;
  logic        in_ready;

  logic [3:0]  tens_q, ones_q;
  logic        dsign_q;
  logic        disp_valid_q;

  logic [CW-1:0] ref_q;
  logic [1:0]    dsel_q;

  logic [6:0] seg_w;
  logic [2:0] an_w;

  // One double-dabble iteration: correct both BCD nibbles, then shift everything left.
  function automatic logic [12:0] dabble_step(input logic [12:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[12:9];
    o = v[8:5];
    if (t >= 4'd5) t = t + 4'd3;
    if (o >= 4'd5) o = o + 4'd3;
    return {t[2:0], o, v[4:0], 1'b0};
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Control FSM and conversion datapath next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    sign_d    = sign_q;
    commit    = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          scratch_d = {8'h00, bus.S};
          sign_d    = bus.sign;
          iter_d    = 3'd0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = dabble_step(scratch_q);
        iter_d    = iter_q + 3'd1;
        if (iter_q == LAST_IT) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: scratch, counter and captured sign are reloaded on every accept, so they need no reset.
  always_ff @(posedge clk) begin
    scratch_q <= scratch_d;
    iter_q    <= iter_d;
    sign_q    <= sign_d;
  end

  // Display registers hold the last committed result until the next commit or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      dsign_q      <= 1'b0;
      disp_valid_q <= 1'b0;
    end else if (commit) begin
      tens_q       <= scratch_d[12:9];
      ones_q       <= scratch_d[8:5];
      dsign_q      <= sign_q;
      disp_valid_q <= 1'b1;
    end
  end

  // Free-running digit scan, independent of conversion activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q  <= '0;
      dsel_q <= 2'd0;
    end else if (ref_q == REF_LAST) begin
      ref_q  <= '0;
      dsel_q <= (dsel_q == 2'd2) ? 2'd0 : dsel_q + 2'd1;
    end else begin
      ref_q  <= ref_q + CW'(1);
    end
  end

  // Segment/anode drive; leading tens zero is suppressed, ones always shown.
  always_comb begin
    seg_w = SEG_BLANK;
    an_w  = 3'b111;
    unique case (dsel_q)
      2'd0: begin
        an_w = 3'b110;
        if (disp_valid_q) seg_w = digit_seg(ones_q);
      end
      2'd1: begin
        an_w = 3'b101;
        if (disp_valid_q && tens_q != 4'd0) seg_w = digit_seg(tens_q);
      end
      2'd2: begin
        an_w = 3'b011;
        if (disp_valid_q && dsign_q) seg_w = SEG_MINUS;
      end
      default: an_w = 3'b111;
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.disp_valid = disp_valid_q;
  assign bus.seg        = seg_w;
  assign bus.an         = an_w;

endmodule

// File: tb/tb_addsub_result_display.sv
// Scoreboard bench for addsub_result_display: stimulus pushes expected digit patterns,
// a negedge monitor pops them on each commit and checks the scanned display every cycle.
module tb_addsub_result_display;

  localparam int DIV = 4;

  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;

  typedef struct packed {
    logic [6:0] sgn;
    logic [6:0] tens;
    logic [6:0] ones;
  } disp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  addsub_result_display_if bus();

  addsub_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  disp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return BLANK;
    endcase
  endfunction

  function automatic disp_t model(input int s, input bit sg);
    disp_t d;
    d.sgn  = sg ? MINUS : BLANK;
    d.tens = (s / 10 == 0) ? BLANK : dig(s / 10);
    d.ones = dig(s % 10);
    return d;
  endfunction

  // Reference scan position: counter 0..DIV-1, select advances on wrap.
  int ref_cnt = 0;
  int dsel    = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= 0;
      dsel    <= 0;
    end else if (ref_cnt == DIV - 1) begin
      ref_cnt <= 0;
      dsel    <= (dsel == 2) ? 0 : dsel + 1;
    end else begin
      ref_cnt <= ref_cnt + 1;
    end
  end

  // Monitor: a 0->1 transition of in_ready outside reset marks a commit.
  initial begin
    disp_t      cur;
    logic       cur_valid;
    logic       prev_ready;
    logic [6:0] eseg;
    logic [2:0] ean;
    cur        = '{BLANK, BLANK, BLANK};
    cur_valid  = 1'b0;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_valid = 1'b0;
      end else begin
        if (!prev_ready && bus.in_ready) begin
          check("commit_has_pending_result", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
          end
        end
        ean = ~(3'b001 << dsel);
        if (!cur_valid) eseg = BLANK;
        else if (dsel == 0) eseg = cur.ones;
        else if (dsel == 1) eseg = cur.tens;
        else eseg = cur.sgn;
        check("an", 32'(bus.an), 32'(ean));
        check("seg", 32'(bus.seg), 32'(eseg));
        check("disp_valid", 32'(bus.disp_valid), 32'(cur_valid));
      end
      prev_ready = bus.in_ready;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_send", 32'(bus.in_ready), 32'd1);
  endtask

  // Called #1 after the accept edge: counts cycles with in_ready low.
  task automatic wait_busy(input string name);
    int n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'd5);
  endtask

  task automatic send(input logic [4:0] s, input logic sg, input disp_t e);
    wait_ready();
    bus.S        = s;
    bus.sign     = sg;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_busy("busy_cycles");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.S        = 5'd0;
    bus.sign     = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_disp_valid", 32'(bus.disp_valid), 32'd0);
    check("reset_an", 32'(bus.an), 32'b110);
    check("reset_seg", 32'(bus.seg), 32'h7F);
    idle(14);

    send(5'd25, 1'b0, '{7'h7F, 7'h24, 7'h12});
    idle(13);
    send(5'd7, 1'b1, '{7'h3F, 7'h7F, 7'h78});
    idle(13);
    send(5'd0, 1'b0, '{7'h7F, 7'h7F, 7'h40});
    idle(13);
    send(5'd0, 1'b1, '{7'h3F, 7'h7F, 7'h40});
    idle(13);

    // Second value held valid through the first conversion.
    wait_ready();
    bus.S        = 5'd31;
    bus.sign     = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back('{7'h7F, 7'h30, 7'h79});
    @(posedge clk);
    #1;
    bus.S = 5'd9;
    exp_q.push_back('{7'h7F, 7'h7F, 7'h10});
    wait_busy("held_first_busy");
    @(posedge clk);
    #1;
    check("held_second_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    wait_busy("held_second_busy");
    idle(13);

    // Reset two cycles into a conversion of 18.
    wait_ready();
    bus.S        = 5'd18;
    bus.sign     = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    check("abort_disp_valid", 32'(bus.disp_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_seg", 32'(bus.seg), 32'h7F);
    idle(16);

    for (int s = 0; s < 32; s++) begin
      for (int sg = 0; sg < 2; sg++) begin
        send(5'(s), 1'(sg), model(s, sg[0]));
        idle(13);
      end
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
